i2c_xfer_arbiter: RTL

I2C_XFER_ARBITER -- requirements
Module: i2c_xfer_arbiter

---
 rtl/i2c_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/i2c_xfer_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared FSM states, response codes and counter sizing for the I2C transfer arbiter
package i2c_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DRAIN,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_NACK    = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin picker; search starts at the pointer, pointer moves past each winner
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;

    always_comb begin
        grant  = '0;
        idx    = '0;
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = IW'((int'(r_ptr) + i) % N);
            if (req[w_cand]) begin
                grant         = '0;
                grant[w_cand] = 1'b1;
                idx           = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (advance && |req)
            r_ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
endmodule

// File: rtl/i2c_xfer_arbiter.sv
// i2c_xfer_arbiter: round-robin sharing of one I2C master among NUM_REQ requesters with NACK retry and watchdog
module i2c_xfer_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MAX_RETRY      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][7:0][7:0]  req_data,
    input  logic [NUM_REQ-1:0][2:0]       req_num_bytes,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [1:0]                    rsp_status,
    output logic                          m_start,
    output logic [7:0][7:0]               m_data_array,
    output logic [2:0]                    m_num_bytes,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic                          m_ack_error
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW = cnt_width(TIMEOUT_CYCLES);
    localparam int RTW = cnt_width(MAX_RETRY);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [RTW-1:0] RT_MAX  = RTW'(MAX_RETRY);

    state_t               r_state, w_next;
    logic [NUM_REQ-1:0]   r_gnt, w_arb_gnt;
    logic [IW-1:0]        w_arb_idx;
    logic [7:0][7:0]      r_data;
    logic [2:0]           r_nbytes;
    rsp_status_t          r_status;
    logic [RTW-1:0]       r_retry;
    logic [WDW-1:0]       r_wdog;
    logic                 w_grant, w_timeout, w_retry, w_watch;

    assign w_grant   = (r_state == S_IDLE) && |req && !m_busy;
    assign w_watch   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_timeout = r_wdog >= WD_LAST;
    assign w_retry   = (r_status == RSP_NACK) && (r_retry < RT_MAX);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (w_grant),
        .grant   (w_arb_gnt),
        .idx     (w_arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        m_start   = r_state == S_LAUNCH;
        gnt       = (r_state == S_RESP) ? '0 : r_gnt;
        rsp_valid = (r_state == S_RESP) ? r_gnt : '0;
        case (r_state)
            S_IDLE:      w_next = w_grant ? S_LAUNCH : S_IDLE;
            S_LAUNCH:    w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: w_next = m_busy ? S_WAIT_DONE : w_timeout ? S_DRAIN : S_WAIT_BUSY;
            S_WAIT_DONE: w_next = (m_done || w_timeout) ? S_DRAIN : S_WAIT_DONE;
            S_DRAIN:     w_next = m_busy ? S_DRAIN : w_retry ? S_LAUNCH : S_RESP;
            S_RESP:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Retry count is cleared at grant so a NACK relaunch keeps its attempt history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_data   <= '0;
            r_nbytes <= '0;
            r_status <= RSP_OK;
            r_retry  <= '0;
            r_wdog   <= '0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_arb_gnt;
                r_data   <= req_data[w_arb_idx];
                r_nbytes <= req_num_bytes[w_arb_idx];
                r_retry  <= '0;
            end
            if (r_state == S_LAUNCH) begin
                r_wdog   <= '0;
                r_status <= RSP_OK;
            end
            if (w_watch)
                r_wdog <= (r_wdog == WD_MAX) ? r_wdog : r_wdog + WDW'(1);
            if (w_watch && w_next == S_DRAIN)
                r_status <= (r_state == S_WAIT_DONE && m_done) ?
                            (m_ack_error ? RSP_NACK : RSP_OK) : RSP_TIMEOUT;
            if (r_state == S_DRAIN && w_next == S_LAUNCH)
                r_retry <= r_retry + RTW'(1);
            if (r_state == S_RESP)
                r_gnt <= '0;
        end
    end

    assign rsp_status   = r_status;
    assign m_data_array = r_data;
    assign m_num_bytes  = r_nbytes;
endmodule
